ecc_scrub_ctrl: RTL and testbench

Controller and arbiter in front of one single-port, ECC-protected word array. The array stores 26 data bits plus 5 check bits and 1 overall parity bit (SECDED). The block shares the array between one host requester and a background scrubber. The scrubber periodically reads every word, and the block writes back corrected data after any single-bit error, whether found by a host read or by the scrubber. It sits between the core-side memory port and the ECC memory wrapper, which generates check bits on write and corrects/flags on read.

---
 rtl/ecc_scrub_ctrl_if.sv | 25 ++
 rtl/ecc_scrub_ctrl.sv | 216 +++++++++++++++++++++
 tb/tb_ecc_scrub_ctrl.sv | 304 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ecc_scrub_ctrl_if.sv
// Host-side request/response bus of ecc_scrub_ctrl.
// master: the requester driving host_req/we/addr/wdata.
// slave:  the controller returning grant, read data and error flag.
interface ecc_scrub_ctrl_if #(
  parameter int unsigned ADDR_W = 6
);
  logic              host_req;
  logic              host_we;
  logic [ADDR_W-1:0] host_addr;
  logic [25:0]       host_wdata;
  logic              host_gnt;
  logic              host_rvalid;
  logic [25:0]       host_rdata;
  logic              host_err;

  modport master (
    output host_req, host_we, host_addr, host_wdata,
    input  host_gnt, host_rvalid, host_rdata, host_err
  );

  modport slave (
    input  host_req, host_we, host_addr, host_wdata,
    output host_gnt, host_rvalid, host_rdata, host_err
  );
endinterface

// File: rtl/ecc_scrub_ctrl.sv
// ecc_scrub_ctrl: arbiter between a host port and a background scrubber in front of one
// single-port SECDED word array. Any read that reports a corrected single-bit error is
// followed by a write-back of the corrected word. Host reads and scrub reads both do this.
// Optional macro ECC_SCRUB_STATS_EN adds saturating SEC/DED counters and the address of the
// last uncorrectable error. Without the macro those outputs are tied to zero.
module ecc_scrub_ctrl #(
  parameter int unsigned ADDR_W       = 6,
  parameter int unsigned DEPTH        = 64,
  parameter int unsigned SCRUB_PERIOD = 256,
  parameter int unsigned MAX_DEFER    = 15,
  parameter int unsigned CNT_W        = 16
) (
  input  logic               i_clock,
  input  logic               i_reset,
  ecc_scrub_ctrl_if.slave    io_host,
  input  logic               i_scrub_en,
  output logic               o_scrub_busy,
  output logic               o_ram_en,
  output logic               o_ram_we,
  output logic [ADDR_W-1:0]  o_ram_addr,
  output logic [25:0]        o_ram_wdata,
  input  logic [25:0]        i_ram_rdata,
  input  logic               i_ram_sec,
  input  logic               i_ram_ded,
  output logic [CNT_W-1:0]   o_sec_count,
  output logic [CNT_W-1:0]   o_ded_count,
  output logic [ADDR_W-1:0]  o_ded_addr
);

  localparam int unsigned TimerW = $clog2(SCRUB_PERIOD);
  localparam int unsigned DeferW = (MAX_DEFER < 1) ? 1 : $clog2(MAX_DEFER + 1);

  typedef enum logic [1:0] {
    StIdle,
    StRdWait,
    StWb
  } state_e;

  state_e             r_state;
  state_e             w_state_d;

  logic               r_is_scrub;    // requester of the read in flight
  logic [ADDR_W-1:0]  r_addr;        // address of the read in flight / write-back target
  logic [25:0]        r_wb_data;     // corrected word awaiting write-back

  logic [TimerW-1:0]  r_timer;
  logic               r_scrub_pending;
  logic [DeferW-1:0]  r_defer_cnt;
  logic [ADDR_W-1:0]  r_scrub_ptr;

  logic               w_host_gnt;
  logic               w_scrub_issue;
  logic               w_defer_max;
  logic               w_timer_exp;
  logic               w_rvalid;

  assign w_defer_max = r_scrub_pending && (r_defer_cnt == DeferW'(MAX_DEFER));
  assign w_timer_exp = i_scrub_en && (r_timer == TimerW'(SCRUB_PERIOD - 1));

  // Arbitration, array port drive and next state; reset masks every array access.
  always_comb begin
    w_state_d     = r_state;
    w_host_gnt    = 1'b0;
    w_scrub_issue = 1'b0;
    o_ram_en      = 1'b0;
    o_ram_we      = 1'b0;
    o_ram_addr    = '0;
    o_ram_wdata   = '0;
    unique case (r_state)
      StIdle: begin
        if (io_host.host_req && !w_defer_max) begin
          w_host_gnt = 1'b1;
          o_ram_en   = 1'b1;
          o_ram_we   = io_host.host_we;
          o_ram_addr = io_host.host_addr;
          if (io_host.host_we) begin
            o_ram_wdata = io_host.host_wdata;
          end else begin
            w_state_d = StRdWait;
          end
        end else if (r_scrub_pending) begin
          w_scrub_issue = 1'b1;
          o_ram_en      = 1'b1;
          o_ram_addr    = r_scrub_ptr;
          w_state_d     = StRdWait;
        end
      end
      StRdWait: begin
        // A double error is never written back, even if SEC is also flagged.
        if (i_ram_sec && !i_ram_ded) begin
          w_state_d = StWb;
        end else begin
          w_state_d = StIdle;
        end
      end
      StWb: begin
        o_ram_en    = 1'b1;
        o_ram_we    = 1'b1;
        o_ram_addr  = r_addr;
        o_ram_wdata = r_wb_data;
        w_state_d   = StIdle;
      end
      default: w_state_d = StIdle;
    endcase
    if (i_reset) begin
      w_state_d     = StIdle;
      w_host_gnt    = 1'b0;
      w_scrub_issue = 1'b0;
      o_ram_en      = 1'b0;
      o_ram_we      = 1'b0;
      o_ram_addr    = '0;
      o_ram_wdata   = '0;
    end
  end

  // Host response is the wrapper's corrected data, presented only for host reads.
  always_comb begin
    w_rvalid            = (r_state == StRdWait) && !r_is_scrub && !i_reset;
    io_host.host_gnt    = w_host_gnt;
    io_host.host_rvalid = w_rvalid;
    io_host.host_rdata  = w_rvalid ? i_ram_rdata : '0;
    io_host.host_err    = w_rvalid && i_ram_ded;
    o_scrub_busy        = !i_reset && (w_scrub_issue || ((r_state != StIdle) && r_is_scrub));
  end

  // State register plus the context of the access in flight.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state    <= StIdle;
      r_is_scrub <= 1'b0;
      r_addr     <= '0;
      r_wb_data  <= '0;
    end else begin
      r_state <= w_state_d;
      if (w_host_gnt && !io_host.host_we) begin
        r_is_scrub <= 1'b0;
        r_addr     <= io_host.host_addr;
      end else if (w_scrub_issue) begin
        r_is_scrub <= 1'b1;
        r_addr     <= r_scrub_ptr;
      end
      if ((r_state == StRdWait) && i_ram_sec && !i_ram_ded) begin
        r_wb_data <= i_ram_rdata;
      end
    end
  end

  // Scrub timer, pending flag, deferral count and scrub address pointer.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_timer         <= '0;
      r_scrub_pending <= 1'b0;
      r_defer_cnt     <= '0;
      r_scrub_ptr     <= '0;
    end else begin
      if (!i_scrub_en || w_timer_exp) begin
        r_timer <= '0;
      end else begin
        r_timer <= r_timer + TimerW'(1);
      end
      // Expiry while a scrub is already pending is dropped, not queued.
      if (r_scrub_pending) begin
        if (w_scrub_issue) begin
          r_scrub_pending <= 1'b0;
        end
      end else if (w_timer_exp) begin
        r_scrub_pending <= 1'b1;
      end
      if (w_scrub_issue) begin
        r_defer_cnt <= '0;
      end else if (r_scrub_pending && w_host_gnt && !w_defer_max) begin
        r_defer_cnt <= r_defer_cnt + DeferW'(1);
      end
      if ((r_state == StRdWait) && r_is_scrub) begin
        if (r_scrub_ptr == ADDR_W'(DEPTH - 1)) begin
          r_scrub_ptr <= '0;
        end else begin
          r_scrub_ptr <= r_scrub_ptr + ADDR_W'(1);
        end
      end
    end
  end

`ifdef ECC_SCRUB_STATS_EN
  logic [CNT_W-1:0]  r_sec_count;
  logic [CNT_W-1:0]  r_ded_count;
  logic [ADDR_W-1:0] r_ded_addr;

  // Saturating error statistics, updated when read results arrive.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_sec_count <= '0;
      r_ded_count <= '0;
      r_ded_addr  <= '0;
    end else if (r_state == StRdWait) begin
      if (i_ram_ded) begin
        if (r_ded_count != '1) begin
          r_ded_count <= r_ded_count + CNT_W'(1);
        end
        r_ded_addr <= r_addr;
      end else if (i_ram_sec && (r_sec_count != '1)) begin
        r_sec_count <= r_sec_count + CNT_W'(1);
      end
    end
  end

  assign o_sec_count = r_sec_count;
  assign o_ded_count = r_ded_count;
  assign o_ded_addr  = r_ded_addr;
`else
  assign o_sec_count = '0;
  assign o_ded_count = '0;
  assign o_ded_addr  = '0;
`endif

endmodule

// File: tb/tb_ecc_scrub_ctrl.sv
// Self-checking bench for ecc_scrub_ctrl. The bench plays the ECC memory wrapper with an
// error-injection plan. A transaction-level model predicts every output each cycle.
module tb_ecc_scrub_ctrl;
  localparam int unsigned AW    = 6;
  localparam int unsigned DEPTH = 64;
  localparam int unsigned PER   = 8;
  localparam int unsigned MAXD  = 15;
  localparam int unsigned CW    = 4;
  localparam int          CMAX  = (1 << CW) - 1;
`ifdef ECC_SCRUB_STATS_EN
  localparam bit Stats = 1'b1;
`else
  localparam bit Stats = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          scrub_en = 1'b0;
  logic [25:0]   ram_rdata = '0;
  logic          ram_sec = 1'b0, ram_ded = 1'b0;
  logic          ram_en, ram_we, scrub_busy;
  logic [AW-1:0] ram_addr, ded_addr;
  logic [25:0]   ram_wdata;
  logic [CW-1:0] sec_count, ded_count;

  ecc_scrub_ctrl_if #(.ADDR_W(AW)) hbus ();

  ecc_scrub_ctrl #(
    .ADDR_W(AW), .DEPTH(DEPTH), .SCRUB_PERIOD(PER), .MAX_DEFER(MAXD), .CNT_W(CW)
  ) dut (
    .i_clock(clk), .i_reset(rst), .io_host(hbus), .i_scrub_en(scrub_en),
    .o_scrub_busy(scrub_busy), .o_ram_en(ram_en), .o_ram_we(ram_we), .o_ram_addr(ram_addr),
    .o_ram_wdata(ram_wdata), .i_ram_rdata(ram_rdata), .i_ram_sec(ram_sec),
    .i_ram_ded(ram_ded), .o_sec_count(sec_count), .o_ded_count(ded_count),
    .o_ded_addr(ded_addr)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          we;
    int          addr;
    logic [25:0] data;
  } op_t;

  int n_cmp = 0, n_bad = 0, cyc = 0;
  op_t host_q[$];
  int  inj_q[$];               // 0 clean, 1 SEC, 2 DED for successive reads
  bit  rand_host = 0, rand_err = 0, rand_rst = 0, rst_after_gnt = 0, se_req = 0;
  int  rst_hold = 0;
  logic [25:0] mem [DEPTH];

  // Observation records (actual DUT activity) for the directed literal checks.
  int          gnt_q[$], sc_cyc[$], sc_addr[$];
  logic [25:0] rv_data[$];
  bit          rv_err[$];
  int          n_wr = 0, n_wr9 = 0;

  // Model: outstanding read response, scheduled write-back, scrub scheduling, stats.
  bit          rsp_v = 0, rsp_scrub = 0, wb_v = 0, wb_scrub = 0, m_pending = 0;
  int          rsp_addr = 0, wb_addr = 0, m_timer = 0, m_defer = 0, m_ptr = 0;
  int          m_sec = 0, m_ded = 0, m_ded_addr = 0;
  logic [25:0] wb_data = '0;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step();
    bit idle, e_gnt, e_scrub, e_en, e_we, e_rv, e_busy, expire, old_pend, nw;
    bit rd_now, wr_now, gnt_now;
    int e_addr, rd_addr, wr_addr, kind;
    logic [25:0] e_wdata, wr_data;
    op_t op;
    @(negedge clk);
    e_gnt = 0; e_scrub = 0; e_en = 0; e_we = 0; e_rv = 0; e_busy = 0;
    e_addr = 0; e_wdata = '0;
    idle = !rsp_v && !wb_v;
    if (!rst) begin
      e_gnt   = idle && hbus.host_req && !(m_pending && m_defer == MAXD);
      e_scrub = idle && m_pending && !e_gnt;
      if (wb_v) begin
        e_en = 1; e_we = 1; e_addr = wb_addr; e_wdata = wb_data;
      end else if (e_gnt) begin
        e_en = 1; e_we = hbus.host_we; e_addr = int'(hbus.host_addr); e_wdata = hbus.host_wdata;
      end else if (e_scrub) begin
        e_en = 1; e_addr = m_ptr;
      end
      e_rv   = rsp_v && !rsp_scrub;
      e_busy = e_scrub || (rsp_v && rsp_scrub) || (wb_v && wb_scrub);
    end
    check("host_gnt", hbus.host_gnt, e_gnt);
    check("host_rvalid", hbus.host_rvalid, e_rv);
    if (e_rv) begin
      check("host_rdata", hbus.host_rdata, ram_rdata);
      check("host_err", hbus.host_err, ram_ded);
    end else if (rst) begin
      check("host_rdata_rst", hbus.host_rdata, 0);
      check("host_err_rst", hbus.host_err, 0);
    end
    check("ram_en", ram_en, e_en);
    if (e_en) begin
      check("ram_we", ram_we, e_we);
      check("ram_addr", ram_addr, e_addr);
      if (e_we) check("ram_wdata", ram_wdata, e_wdata);
    end else if (rst) begin
      check("ram_we_rst", ram_we, 0);
      check("ram_addr_rst", ram_addr, 0);
      check("ram_wdata_rst", ram_wdata, 0);
    end
    check("scrub_busy", scrub_busy, e_busy);
    check("sec_count", sec_count, Stats ? m_sec : 0);
    check("ded_count", ded_count, Stats ? m_ded : 0);
    check("ded_addr", ded_addr, Stats ? m_ded_addr : 0);

    gnt_now = (hbus.host_gnt === 1'b1);
    rd_now  = (ram_en === 1'b1) && (ram_we === 1'b0);
    wr_now  = (ram_en === 1'b1) && (ram_we === 1'b1);
    rd_addr = int'(ram_addr);
    wr_addr = int'(ram_addr);
    wr_data = ram_wdata;
    if (gnt_now) gnt_q.push_back(cyc);
    if (rd_now && !gnt_now) begin
      sc_cyc.push_back(cyc);
      sc_addr.push_back(rd_addr);
    end
    if (hbus.host_rvalid === 1'b1) begin
      rv_data.push_back(hbus.host_rdata);
      rv_err.push_back(hbus.host_err);
    end
    if (wr_now) begin
      n_wr++;
      if (wr_addr == 9) n_wr9++;
    end

    if (rst) begin
      rsp_v = 0; rsp_scrub = 0; wb_v = 0; wb_scrub = 0; m_pending = 0;
      m_timer = 0; m_defer = 0; m_ptr = 0; m_sec = 0; m_ded = 0; m_ded_addr = 0;
    end else begin
      nw = 0;
      if (rsp_v) begin
        if (ram_ded) begin
          if (m_ded < CMAX) m_ded++;
          m_ded_addr = rsp_addr;
        end else if (ram_sec) begin
          if (m_sec < CMAX) m_sec++;
          nw = 1; wb_addr = rsp_addr; wb_data = ram_rdata; wb_scrub = rsp_scrub;
        end
        if (rsp_scrub) m_ptr = (m_ptr + 1) % DEPTH;
      end
      wb_v      = nw;
      rsp_v     = (e_gnt && !hbus.host_we) || e_scrub;
      rsp_scrub = e_scrub;
      rsp_addr  = e_addr;
      expire    = scrub_en && (m_timer == PER - 1);
      old_pend  = m_pending;
      if (e_scrub) begin
        m_pending = 0; m_defer = 0;
      end else if (old_pend && e_gnt && m_defer < MAXD) begin
        m_defer++;
      end
      if (!old_pend && expire) m_pending = 1;
      m_timer = (!scrub_en || expire) ? 0 : m_timer + 1;
    end

    @(posedge clk);
    #1;
    if (wr_now && !rst) mem[wr_addr] = wr_data;
    if (gnt_now) begin
      hbus.host_req = 1'b0;
      if (rst_after_gnt) begin
        rst_hold = 1;
        rst_after_gnt = 0;
      end
    end
    if (rd_now) begin
      if (inj_q.size() > 0) kind = inj_q.pop_front();
      else if (rand_err) kind = ($urandom_range(0, 9) < 6) ? 0 : int'($urandom_range(1, 2));
      else kind = 0;
      ram_sec   = (kind == 1) ? 1'b1 : ((kind == 2) ? 1'($urandom_range(0, 1)) : 1'b0);
      ram_ded   = (kind == 2);
      ram_rdata = (kind == 2) ? 26'($urandom) : mem[rd_addr];
    end else begin
      ram_rdata = 26'($urandom);
      ram_sec   = 1'($urandom_range(0, 1));
      ram_ded   = 1'($urandom_range(0, 1));
    end
    if (!hbus.host_req) begin
      if (host_q.size() > 0) begin
        op = host_q.pop_front();
      end else if (rand_host && $urandom_range(0, 2) == 0) begin
        op.we = 1'($urandom_range(0, 1)); op.addr = int'($urandom_range(0, DEPTH - 1));
        op.data = 26'($urandom);
      end else begin
        op.addr = -1;
      end
      if (op.addr >= 0) begin
        hbus.host_req = 1'b1; hbus.host_we = op.we;
        hbus.host_addr = AW'(op.addr); hbus.host_wdata = op.data;
      end
    end
    if (rand_rst && $urandom_range(0, 399) == 0) rst_hold = 1;
    rst = (rst_hold > 0);
    if (rst_hold > 0) rst_hold--;
    scrub_en = se_req;
    cyc++;
  endtask

  initial begin
    int start, first_sc, n_before, next_gnt, bad, rv0, wr0;
    hbus.host_req = 1'b0; hbus.host_we = 1'b0; hbus.host_addr = '0; hbus.host_wdata = '0;
    for (int i = 0; i < DEPTH; i++) mem[i] = 26'($urandom);
    rst_hold = 1;
    repeat (3) step();

    // Directed host write/read, SEC read with write-back, DED read.
    host_q.push_back('{1'b1, 5, 26'h2ABCDEF});
    host_q.push_back('{1'b0, 5, 26'h0});
    host_q.push_back('{1'b1, 9, 26'h0000123});
    host_q.push_back('{1'b0, 9, 26'h0});
    host_q.push_back('{1'b0, 3, 26'h0});
    inj_q.push_back(0); inj_q.push_back(1); inj_q.push_back(2);
    repeat (20) step();
    check("rv_count", rv_data.size(), 3);
    if (rv_data.size() >= 3) begin
      check("rd5_data", rv_data[0], 26'h2ABCDEF);
      check("rd5_err", rv_err[0], 0);
      check("rd9_data", rv_data[1], 26'h0000123);
      check("rd3_err", rv_err[2], 1);
    end
    check("wr9_count", n_wr9, 2);
    check("mem9", mem[9], 26'h0000123);
    check("sec_lit", sec_count, Stats ? 1 : 0);
    check("ded_lit", ded_count, Stats ? 1 : 0);
    check("ded_addr_lit", ded_addr, Stats ? 3 : 0);

    // Scrub sweep with an idle host: one read every PER cycles, pointer wraps.
    sc_cyc.delete(); sc_addr.delete();
    se_req = 1;
    step();
    repeat (PER * 66 + 4) step();
    check("scrub_reads", sc_cyc.size(), 66);
    bad = 0;
    for (int i = 0; i < sc_cyc.size(); i++) begin
      if (sc_addr[i] != i % DEPTH) bad++;
      if (i > 0 && sc_cyc[i] - sc_cyc[i-1] != PER) bad++;
    end
    check("scrub_seq_errs", bad, 0);
    if (sc_addr.size() >= 65) begin
      check("scrub_addr63", sc_addr[63], 63);
      check("scrub_wrap", sc_addr[64], 0);
    end

    // Host held continuously: scrub wins after exactly MAXD deferrals.
    se_req = 0;
    repeat (20) step();
    gnt_q.delete(); sc_cyc.delete(); sc_addr.delete();
    for (int i = 0; i < 40; i++) host_q.push_back('{1'b1, i % DEPTH, 26'($urandom)});
    se_req = 1;
    step();
    start = cyc;
    repeat (40) step();
    first_sc = (sc_cyc.size() > 0) ? sc_cyc[0] - start : -1;
    n_before = 0;
    next_gnt = -1;
    foreach (gnt_q[i]) begin
      if (gnt_q[i] - start < first_sc) n_before++;
      else if (next_gnt < 0) next_gnt = gnt_q[i] - start;
    end
    check("defer_scrub_cycle", first_sc, 23);
    check("defer_grants", n_before, 23);
    check("host_after_scrub", next_gnt, 25);
    se_req = 0;
    host_q.delete();
    repeat (30) step();

    // Reset during the response cycle of a SEC host read.
    rv0 = rv_data.size();
    wr0 = n_wr;
    host_q.push_back('{1'b0, 9, 26'h0});
    inj_q.push_back(1);
    rst_after_gnt = 1;
    repeat (6) step();
    check("rst_no_rvalid", rv_data.size(), rv0);
    check("rst_no_wb", n_wr, wr0);
    check("rst_sec_count", sec_count, 0);

    // Randomised traffic, errors, scrub enable toggles and occasional resets.
    rand_host = 1; rand_err = 1; rand_rst = 1;
    for (int i = 0; i < 3000; i++) begin
      if (i % 100 == 0) se_req = 1'($urandom_range(0, 3) != 0);
      step();
    end
    rand_host = 0; rand_rst = 0; se_req = 0;
    repeat (20) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
